pokey_io_regs: RTL and testbench

POKEY_IO_REGS -- requirements
Module: pokey_io_regs

---
 rtl/pokey_io_regs.sv | 154 +++++++++++++++
 tb/tb_pokey_io_regs.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pokey_io_regs.sv
// POKEY-style CPU register file: pot scan latches, ALLPOT, keyboard code,
// key interrupt and SKSTAT, with a three-state pot scan FSM.
module pokey_io_regs (
  input  logic       o2,
  input  logic       rst_L,
  input  logic       cs,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic [7:0] pot0_in,
  input  logic [7:0] pot1_in,
  input  logic [7:0] pot_scan,
  input  logic [3:0] keycode_in,
  output logic       potgo,
  output logic       irq_L
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} pot_st_e;

  localparam logic [7:0] LAST_LINE = 8'd227;
  localparam logic [7:0] NO_CAP    = 8'd228;

  pot_st_e    state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pot0_q, pot0_d, pot1_q, pot1_d;
  logic       cap0_q, cap0_d, cap1_q, cap1_d;
  logic [7:0] allpot_q, allpot_d;
  logic       potgo_q, potgo_d;
  logic [3:0] key_q, key_d;
  logic [3:0] kbcode_q, kbcode_d;
  logic       keypend_q, keypend_d;
  logic       ovr_q, ovr_d;
  logic [7:0] irqen_q, irqen_d;

  logic wr_en, potgo_wr, irqen_wr, key_evt;

  assign wr_en    = cs & ~rw;
  assign potgo_wr = wr_en && (addr == 4'hB);
  assign irqen_wr = wr_en && (addr == 4'hE);
  // Comparing against the registered code catches both press and key-change.
  assign key_evt  = (keycode_in != 4'h0) && (keycode_in != key_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pot0_d    = pot0_q;
    pot1_d    = pot1_q;
    cap0_d    = cap0_q;
    cap1_d    = cap1_q;
    allpot_d  = allpot_q;
    potgo_d   = potgo_wr;
    key_d     = keycode_in;
    kbcode_d  = kbcode_q;
    keypend_d = keypend_q;
    ovr_d     = ovr_q;
    irqen_d   = irqen_q;

    if (state_q == SCAN) begin
      cnt_d    = cnt_q + 8'd1;
      allpot_d = allpot_q & ~pot_scan;
      if (pot_scan[0] && !cap0_q) begin
        pot0_d = pot0_in;
        cap0_d = 1'b1;
      end
      if (pot_scan[1] && !cap1_q) begin
        pot1_d = pot1_in;
        cap1_d = 1'b1;
      end
      if (cnt_q == LAST_LINE) begin
        state_d  = DONE;
        allpot_d = 8'h00;
        if (!cap0_d) pot0_d = NO_CAP;
        if (!cap1_d) pot1_d = NO_CAP;
      end
    end

    // Restart overrides whatever the scan did this cycle, including DONE entry.
    if (potgo_wr) begin
      state_d  = SCAN;
      cnt_d    = 8'd0;
      allpot_d = 8'hFF;
      pot0_d   = 8'h00;
      pot1_d   = 8'h00;
      cap0_d   = 1'b0;
      cap1_d   = 1'b0;
    end

    if (irqen_wr) begin
      irqen_d = data_in;
      if (!data_in[6]) begin
        keypend_d = 1'b0;
        ovr_d     = 1'b0;
      end
    end

    if (key_evt) begin
      kbcode_d  = keycode_in;
      keypend_d = 1'b1;
      if (keypend_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge o2 or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      pot0_q    <= 8'h00;
      pot1_q    <= 8'h00;
      cap0_q    <= 1'b0;
      cap1_q    <= 1'b0;
      allpot_q  <= 8'h00;
      potgo_q   <= 1'b0;
      key_q     <= 4'h0;
      kbcode_q  <= 4'h0;
      keypend_q <= 1'b0;
      ovr_q     <= 1'b0;
      irqen_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pot0_q    <= pot0_d;
      pot1_q    <= pot1_d;
      cap0_q    <= cap0_d;
      cap1_q    <= cap1_d;
      allpot_q  <= allpot_d;
      potgo_q   <= potgo_d;
      key_q     <= key_d;
      kbcode_q  <= kbcode_d;
      keypend_q <= keypend_d;
      ovr_q     <= ovr_d;
      irqen_q   <= irqen_d;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (cs && rw) begin
      case (addr)
        4'h0:    data_out = pot0_q;
        4'h1:    data_out = pot1_q;
        4'h8:    data_out = allpot_q;
        4'h9:    data_out = {4'h0, kbcode_q};
        4'hE:    data_out = ~{1'b0, keypend_q, 6'b0};
        4'hF:    data_out = {2'b11, ~ovr_q, 2'b11, (key_q == 4'h0), 2'b11};
        default: data_out = 8'h00;
      endcase
    end
  end

  assign potgo = potgo_q;
  assign irq_L = ~(keypend_q & irqen_q[6]);

endmodule

// File: tb/tb_pokey_io_regs.sv
// Directed self-checking bench for pokey_io_regs; expected values hand-derived.
module tb_pokey_io_regs;
  logic       o2 = 1'b0;
  logic       rst_L = 1'b0;
  logic       cs = 1'b0;
  logic       rw = 1'b1;
  logic [3:0] addr = 4'h0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [7:0] pot0_in = 8'h00;
  logic [7:0] pot1_in = 8'h00;
  logic [7:0] pot_scan = 8'h00;
  logic [3:0] keycode_in = 4'h0;
  logic       potgo;
  logic       irq_L;

  int checks = 0;
  int errors = 0;

  pokey_io_regs dut (
    .o2(o2), .rst_L(rst_L), .cs(cs), .rw(rw), .addr(addr), .data_in(data_in),
    .data_out(data_out), .pot0_in(pot0_in), .pot1_in(pot1_in),
    .pot_scan(pot_scan), .keycode_in(keycode_in), .potgo(potgo), .irq_L(irq_L)
  );

  always #5 o2 = ~o2;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge o2);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
    tick();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    cs = 1'b1; rw = 1'b1; addr = a;
    #1;
    chk(tag, data_out, exp);
    cs = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    rd(4'h0, 8'h00, "rst_pot0");
    rd(4'h1, 8'h00, "rst_pot1");
    rd(4'h8, 8'h00, "rst_allpot");
    rd(4'h9, 8'h00, "rst_kbcode");
    rd(4'hE, 8'hFF, "rst_irqst");
    rd(4'hF, 8'hFF, "rst_skstat");
    chk("rst_irq_L", {7'b0, irq_L}, 8'h01);
    chk("rst_potgo", {7'b0, potgo}, 8'h00);
    tick(2);
    rst_L = 1'b1;
    tick(2);
    rd(4'h8, 8'h00, "idle_allpot");
    rd(4'h7, 8'h00, "unmapped_read");

    // Full scan: line 0 hits at counter 50, line 1 never hits
    wr(4'hB, 8'h00);                        // counter now 0
    chk("potgo_pulse", {7'b0, potgo}, 8'h01);
    rd(4'h8, 8'hFF, "scan_allpot_ff");
    tick();                                 // counter 1
    chk("potgo_drop", {7'b0, potgo}, 8'h00);
    tick(49);                               // counter 50
    pot_scan = 8'h01; pot0_in = 8'd50; pot1_in = 8'd99;
    tick();                                 // counter 51
    pot_scan = 8'h00;
    rd(4'h8, 8'hFE, "allpot_fe");
    rd(4'h0, 8'd50, "pot0_cap");
    rd(4'h1, 8'h00, "pot1_not_yet");
    tick(176);                              // counter 227
    rd(4'h8, 8'hFE, "allpot_before_done");
    tick();                                 // DONE
    rd(4'h8, 8'h00, "done_allpot");
    rd(4'h0, 8'd50, "done_pot0");
    rd(4'h1, 8'd228, "done_pot1");
    pot_scan = 8'h03; pot0_in = 8'd7;
    tick(5);
    pot_scan = 8'h00;
    rd(4'h0, 8'd50, "done_hold_pot0");
    rd(4'h8, 8'h00, "done_hold_allpot");

    // Key interrupt with IRQEN enabled, then disabled
    wr(4'hE, 8'h40);
    chk("irq_before_key", {7'b0, irq_L}, 8'h01);
    keycode_in = 4'h5;
    tick();
    rd(4'h9, 8'h05, "kbcode_5");
    rd(4'hE, 8'hBF, "irqst_pend");
    rd(4'hF, 8'hFB, "skstat_keydown");
    chk("irq_asserted", {7'b0, irq_L}, 8'h00);
    wr(4'hE, 8'h00);
    chk("irq_cleared", {7'b0, irq_L}, 8'h01);
    rd(4'hE, 8'hFF, "irqst_cleared");
    keycode_in = 4'h0;
    tick();
    rd(4'h9, 8'h05, "kbcode_hold_on_release");
    rd(4'hF, 8'hFF, "skstat_keyup");

    // Overrun: 0->3->7 with keypend uncleared; keypend sets even with IRQEN=0
    keycode_in = 4'h3;
    tick();
    keycode_in = 4'h7;
    tick();
    rd(4'h9, 8'h07, "kbcode_7");
    rd(4'hF, 8'hDB, "skstat_overrun");
    rd(4'hE, 8'hBF, "irqst_pend_no_en");
    chk("irq_masked", {7'b0, irq_L}, 8'h01);
    wr(4'hE, 8'h00);
    rd(4'hF, 8'hFB, "skstat_ovr_cleared");
    rd(4'hE, 8'hFF, "irqst_clear2");
    keycode_in = 4'h2;                      // event in the same cycle as clear
    wr(4'hE, 8'h00);
    rd(4'hE, 8'hBF, "set_wins_over_clear");
    rd(4'h9, 8'h02, "kbcode_2");
    keycode_in = 4'h0;
    wr(4'hE, 8'h00);

    // Restart mid-scan: POTGO at counter 100, line 1 captured, POTGO at 200
    wr(4'hB, 8'h00);                        // counter 0
    tick(60);                               // counter 60
    pot_scan = 8'h02; pot1_in = 8'd61;
    tick();
    pot_scan = 8'h00;
    rd(4'h1, 8'd61, "pot1_cap");
    rd(4'h8, 8'hFD, "allpot_fd");
    tick(39);                               // counter 100
    wr(4'hB, 8'h00);                        // counter 0
    rd(4'h1, 8'h00, "restart1_pot1_clr");
    rd(4'h8, 8'hFF, "restart1_allpot");
    tick(200);                              // counter 200
    wr(4'hB, 8'h00);                        // counter 0
    chk("restart2_potgo", {7'b0, potgo}, 8'h01);
    tick(227);                              // counter 227
    rd(4'h8, 8'hFF, "restart2_not_done");
    tick();
    rd(4'h8, 8'h00, "restart2_done");
    rd(4'h0, 8'd228, "restart2_pot0");
    rd(4'h1, 8'd228, "restart2_pot1");

    // Reset mid-scan aborts; no DONE afterward
    wr(4'hB, 8'h00);
    tick(20);
    rst_L = 1'b0;
    #1;
    rd(4'h8, 8'h00, "rst_mid_allpot");
    rd(4'h9, 8'h00, "rst_mid_kbcode");
    chk("rst_mid_potgo", {7'b0, potgo}, 8'h00);
    tick();
    rst_L = 1'b1;
    tick(300);
    rd(4'h0, 8'h00, "post_rst_pot0");
    rd(4'h1, 8'h00, "post_rst_pot1");
    rd(4'h8, 8'h00, "post_rst_allpot");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
